// File: rtl/copro_fpu_sched.sv
// rtl/copro_fpu_sched.sv - sequencer between the CPU coprocessor port and the FP adder/multiplier
module copro_fpu_sched #(
  parameter int W       = 32,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             copro_valid_i,
  input  logic [1:0]       copro_opcode_i,
  input  logic [W-1:0]     copro_op0_i,
  input  logic [W-1:0]     copro_op1_i,
  output logic [W-1:0]     copro_result_o,
  output logic             copro_complete_o,
  output logic             busy_o,
  output logic             err_o,
  output logic [CNT_W-1:0] op_count_o,
  output logic             add_start_o,
  output logic             add_sub_o,
  output logic [W-1:0]     add_a_o,
  output logic [W-1:0]     add_b_o,
  input  logic             add_done_i,
  input  logic [W-1:0]     add_res_i,
  output logic             mul_start_o,
  output logic [W-1:0]     mul_a_o,
  output logic [W-1:0]     mul_b_o,
  input  logic             mul_done_i,
  input  logic [W-1:0]     mul_res_i
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [W-1:0] QNAN = W'(32'h7FC0_0000);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP, S_HOLD} state_t;

  state_t           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [W-1:0]     a_q, a_d, b_q, b_d, res_q, res_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic             sel_done;
  logic [W-1:0]     sel_res;

  // opcode 10 is the only legal op that reaches WAIT with op_q[1] set
  assign sel_done = op_q[1] ? mul_done_i : add_done_i;
  assign sel_res  = op_q[1] ? mul_res_i  : add_res_i;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    case (state_q)
      S_IDLE: begin
        if (copro_valid_i) begin
          op_d  = copro_opcode_i;
          a_d   = copro_op0_i;
          b_d   = copro_op1_i;
          err_d = 1'b0;
          tmo_d = '0;
          if (copro_opcode_i == 2'b11) begin
            res_d   = QNAN;
            err_d   = 1'b1;
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = S_RESP;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        // a done on the timeout cycle still returns the unit result
        if (sel_done) begin
          res_d   = sel_res;
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = S_RESP;
        end else begin
          tmo_d = tmo_q + TW'(1);
          if (tmo_q == TW'(TIMEOUT - 1)) begin
            res_d   = QNAN;
            err_d   = 1'b1;
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = S_RESP;
          end
        end
      end
      S_RESP:  state_d = S_HOLD;
      S_HOLD:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
    end
  end

  assign busy_o           = (state_q != S_IDLE);
  assign copro_complete_o = (state_q == S_RESP);
  assign copro_result_o   = res_q;
  assign err_o            = err_q;
  assign op_count_o       = cnt_q;
  assign add_start_o      = (state_q == S_ISSUE) && !op_q[1];
  assign mul_start_o      = (state_q == S_ISSUE) && op_q[1];
  assign add_sub_o        = !op_q[1] && op_q[0];
  assign add_a_o          = a_q;
  assign add_b_o          = b_q;
  assign mul_a_o          = a_q;
  assign mul_b_o          = b_q;

endmodule

// File: tb/tb_copro_fpu_sched.sv
// tb/tb_copro_fpu_sched.sv - vector table plus scoreboard bench for copro_fpu_sched
module tb_copro_fpu_sched;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        copro_valid_i = 1'b0;
  logic [1:0]  copro_opcode_i = 2'b00;
  logic [31:0] copro_op0_i = '0, copro_op1_i = '0;
  logic [31:0] copro_result_o;
  logic        copro_complete_o, busy_o, err_o;
  logic [3:0]  op_count_o;
  logic        add_start_o, add_sub_o, mul_start_o;
  logic [31:0] add_a_o, add_b_o, mul_a_o, mul_b_o;
  logic        add_done_i, mul_done_i;
  logic [31:0] add_res_i, mul_res_i;

  copro_fpu_sched #(.W(32), .TIMEOUT(TMO), .CNT_W(4)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .copro_valid_i(copro_valid_i), .copro_opcode_i(copro_opcode_i),
    .copro_op0_i(copro_op0_i), .copro_op1_i(copro_op1_i),
    .copro_result_o(copro_result_o), .copro_complete_o(copro_complete_o),
    .busy_o(busy_o), .err_o(err_o), .op_count_o(op_count_o),
    .add_start_o(add_start_o), .add_sub_o(add_sub_o),
    .add_a_o(add_a_o), .add_b_o(add_b_o),
    .add_done_i(add_done_i), .add_res_i(add_res_i),
    .mul_start_o(mul_start_o), .mul_a_o(mul_a_o), .mul_b_o(mul_b_o),
    .mul_done_i(mul_done_i), .mul_res_i(mul_res_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b;
    int          lat;
    logic [31:0] ures, eres;
    logic        eerr;
    int          elat;
    int          eadd, emul;
    logic        esub;
    bit          early, spur;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic        err;
    logic [3:0]  cnt;
    int          t0;
    int          lat;
  } exp_t;

  int   checks = 0, failures = 0;
  int   cyc = 0;
  exp_t sb_q[$];
  logic [3:0] exp_cnt = '0;

  logic [1:0]  cur_op = 2'b00;
  int          cur_lat = 0;
  logic [31:0] cur_res = '0;
  logic        add_auto = 1'b0, mul_auto = 1'b0, add_extra = 1'b0, mul_extra = 1'b0;
  int          add_tmr = 0, mul_tmr = 0, add_starts = 0, mul_starts = 0;
  logic        last_sub = 1'b0;

  assign add_done_i = add_auto | add_extra;
  assign mul_done_i = mul_auto | mul_extra;
  assign add_res_i  = cur_op[1] ? 32'hDEAD_BEEF : cur_res;
  assign mul_res_i  = cur_op[1] ? cur_res : 32'hBAD0_F00D;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // unit models: done arrives lat cycles after the start pulse; lat 0 never answers
  always @(negedge clk) begin
    add_auto = 1'b0;
    mul_auto = 1'b0;
    if (add_tmr > 0) begin add_tmr--; if (add_tmr == 0) add_auto = 1'b1; end
    if (mul_tmr > 0) begin mul_tmr--; if (mul_tmr == 0) mul_auto = 1'b1; end
    if (add_start_o) begin
      add_starts++;
      last_sub = add_sub_o;
      if (cur_lat > 0) add_tmr = cur_lat;
    end
    if (mul_start_o) begin
      mul_starts++;
      if (cur_lat > 0) mul_tmr = cur_lat;
    end
  end

  always @(negedge clk) begin
    if (copro_complete_o) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_complete: got result %h expected no completion (cycle %0d)", copro_result_o, cyc);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("result", copro_result_o, e.res);
        chk("err", err_o, e.err);
        chk("op_count", op_count_o, e.cnt);
        chk("latency", cyc - e.t0, e.lat);
      end
    end
  end

  task automatic do_op(input vec_t v);
    int  t0, sa, sm;
    bit  seen;
    exp_t e;
    @(negedge clk);
    if (!v.early) begin
      copro_valid_i = 1'b0;
      @(negedge clk);
    end
    cur_op = v.op; cur_lat = v.lat; cur_res = v.ures;
    copro_valid_i = 1'b1; copro_opcode_i = v.op;
    copro_op0_i = v.a; copro_op1_i = v.b;
    if (v.early) @(negedge clk);
    t0 = cyc; sa = add_starts; sm = mul_starts;
    exp_cnt = exp_cnt + 4'd1;
    e.res = v.eres; e.err = v.eerr; e.cnt = exp_cnt; e.t0 = t0; e.lat = v.elat;
    sb_q.push_back(e);
    seen = 0;
    for (int i = 1; i <= 60 && !seen; i++) begin
      @(negedge clk);
      add_extra = v.spur && (i == 2);
      if (i == 1 && v.op != 2'b11) begin
        chk("err_cleared_on_accept", err_o, 1'b0);
        chk("busy_in_issue", busy_o, 1'b1);
        chk("operand_a", v.op[1] ? mul_a_o : add_a_o, v.a);
        chk("operand_b", v.op[1] ? mul_b_o : add_b_o, v.b);
      end
      if (copro_complete_o) seen = 1;
    end
    add_extra = 1'b0;
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL complete_timeout: got no completion expected one for opcode %0d", v.op);
      void'(sb_q.pop_front());
    end
    chk("add_start_pulses", add_starts - sa, v.eadd);
    chk("mul_start_pulses", mul_starts - sm, v.emul);
    if (v.eadd > 0) chk("add_sub", last_sub, v.esub);
  endtask

  function automatic vec_t mkv(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                               input int lat, input logic [31:0] ures, input logic [31:0] eres,
                               input logic eerr, input int elat, input bit early, input bit spur);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.lat = lat; v.ures = ures; v.eres = eres;
    v.eerr = eerr; v.elat = elat; v.early = early; v.spur = spur;
    v.eadd = (op == 2'b00 || op == 2'b01) ? 1 : 0;
    v.emul = (op == 2'b10) ? 1 : 0;
    v.esub = (op == 2'b01);
    return v;
  endfunction

  vec_t vecs[9];
  bit   saw;

  initial begin
    vecs[0] = mkv(2'b00, 32'h3F80_0000, 32'h4000_0000, 2, 32'h4040_0000, 32'h4040_0000, 1'b0, 4, 0, 0);
    vecs[1] = mkv(2'b01, 32'h40A0_0000, 32'h4040_0000, 3, 32'h4000_0000, 32'h4000_0000, 1'b0, 5, 0, 0);
    vecs[2] = mkv(2'b10, 32'h3FC0_0000, 32'h4000_0000, 2, 32'h4040_0000, 32'h4040_0000, 1'b0, 4, 1, 1);
    vecs[3] = mkv(2'b11, 32'h1111_1111, 32'h2222_2222, 0, 32'h0,         32'h7FC0_0000, 1'b1, 1, 0, 0);
    vecs[4] = mkv(2'b00, 32'h4000_0000, 32'h4000_0000, 1, 32'h4080_0000, 32'h4080_0000, 1'b0, 3, 0, 0);
    vecs[5] = mkv(2'b10, 32'h4000_0000, 32'h4040_0000, 0, 32'h40C0_0000, 32'h7FC0_0000, 1'b1, TMO + 2, 0, 0);
    vecs[6] = mkv(2'b10, 32'h3F80_0000, 32'h3F80_0000, TMO, 32'h3F80_0000, 32'h3F80_0000, 1'b0, TMO + 2, 0, 0);
    vecs[7] = mkv(2'b00, 32'h3F00_0000, 32'h3F00_0000, TMO - 1, 32'h3F80_0000, 32'h3F80_0000, 1'b0, TMO + 1, 0, 0);
    vecs[8] = mkv(2'b01, 32'h4100_0000, 32'h3F80_0000, TMO + 1, 32'h40E0_0000, 32'h7FC0_0000, 1'b1, TMO + 2, 0, 0);

    repeat (2) @(negedge clk);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_complete", copro_complete_o, 1'b0);
    chk("rst_result", copro_result_o, 32'h0);
    chk("rst_err", err_o, 1'b0);
    chk("rst_count", op_count_o, 4'd0);
    chk("rst_starts", {add_start_o, mul_start_o, add_sub_o}, 3'b000);
    chk("rst_operands", add_a_o | add_b_o | mul_a_o | mul_b_o, 32'h0);
    rst_i = 1'b0;

    for (int i = 0; i < 9; i++) begin
      do_op(vecs[i]);
      if (i == 5) begin
        // late multiplier done after the timeout must not complete anything
        @(negedge clk); copro_valid_i = 1'b0;
        @(negedge clk); mul_extra = 1'b1;
        @(negedge clk); mul_extra = 1'b0;
        chk("late_done_idle", busy_o, 1'b0);
      end
    end

    // reset while waiting on the adder; its later done must be ignored
    @(negedge clk); copro_valid_i = 1'b0;
    @(negedge clk);
    cur_op = 2'b00; cur_lat = 5; cur_res = 32'h1234_5678;
    copro_valid_i = 1'b1; copro_opcode_i = 2'b00;
    copro_op0_i = 32'hAAAA_AAAA; copro_op1_i = 32'h5555_5555;
    @(negedge clk);
    chk("rstw_add_start", add_start_o, 1'b1);
    @(negedge clk);
    chk("rstw_busy_wait", busy_o, 1'b1);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0; copro_valid_i = 1'b0;
    chk("rstw_busy", busy_o, 1'b0);
    chk("rstw_result", copro_result_o, 32'h0);
    chk("rstw_err", err_o, 1'b0);
    chk("rstw_count", op_count_o, 4'd0);
    chk("rstw_operands", add_a_o | add_b_o, 32'h0);
    exp_cnt = '0;
    saw = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (copro_complete_o || busy_o) saw = 1;
    end
    chk("rstw_no_complete", saw, 1'b0);

    for (int i = 0; i < 16; i++) begin
      vec_t v;
      logic [31:0] r;
      int lat;
      r = $urandom;
      lat = 1 + (i % 3);
      v = mkv(2'(i % 3), $urandom, $urandom, lat, r, r, 1'b0, lat + 2, 0, 0);
      do_op(v);
      if (i == 14) chk("count_before_wrap", op_count_o, 4'd15);
    end
    chk("count_wrapped", op_count_o, 4'd0);

    @(negedge clk); copro_valid_i = 1'b0;
    repeat (4) @(negedge clk);
    chk("scoreboard_empty", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/copro_fpu_sched.md
Name: copro_fpu_sched

Overview:
- Sequencer between the LM32 user-instruction (coprocessor) interface and the coprocessor's two floating-point units: a shared adder/subtractor and a multiplier.
- Accepts one CPU request at a time, decodes the opcode, and issues a start pulse to the selected unit with latched operands.
- Waits for that unit's done, then returns the result to the CPU with a completion pulse.
- Covers illegal opcodes and unit timeouts with a canonical quiet NaN and a sticky error flag.

Parameters:
- W, 32: operand/result width (sign + Ne+1 exponent + Nm+1 mantissa packing of the float type = 32 at package defaults).
- TIMEOUT, 64: maximum WAIT cycles before abort; must be ≥ 2.
- CNT_W, 16: width of completed-operation counter.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- copro_valid_i  in  1  CPU request; held high until copro_complete_o is sampled, dropped the following cycle.
- copro_opcode_i  in  2  00 add, 01 sub, 10 mul, 11 illegal.
- copro_op0_i  in  W  operand A.
- copro_op1_i  in  W  operand B.
- copro_result_o  out  W  result, valid while copro_complete_o=1.
- copro_complete_o  out  1  one-cycle completion pulse.
- busy_o  out  1  high whenever state ≠ IDLE.
- err_o  out  1  sticky: last op was illegal or timed out; cleared on next accept.
- op_count_o  out  CNT_W  completed operations (including errored ones); wraps.
- add_start_o  out  1  one-cycle start to adder.
- add_sub_o  out  1  1 = subtract; valid with add_start_o.
- add_a_o, add_b_o  out  W each  adder operands; stable from ISSUE until RESP.
- add_done_i  in  1  adder done pulse.
- add_res_i  in  W  adder result, valid with add_done_i.
- mul_start_o  out  1  one-cycle start to multiplier.
- mul_a_o, mul_b_o  out  W each  multiplier operands; stable from ISSUE until RESP.
- mul_done_i  in  1  multiplier done pulse.
- mul_res_i  in  W  multiplier result, valid with mul_done_i.

Behaviour:
- Reset: state IDLE.
  - All outputs 0, including operands, result, err_o and op_count_o.
  - Timeout counter cleared.
  - Reset mid-operation abandons the operation; any later done pulse from a unit is ignored while in IDLE.
- FSM states: IDLE, ISSUE, WAIT, RESP, HOLD.
- IDLE:
  - If copro_valid_i=1: latch opcode and operands, clear err_o, zero the timeout counter.
  - Opcode 00/01/10 → ISSUE. Opcode 11 → RESP with result 32'h7FC00000 and err_o=1.
- ISSUE (exactly 1 cycle):
  - Assert the selected unit's start; the other unit's start stays 0.
  - add_sub_o = opcode[0] for add/sub.
  - Next state WAIT.
  - Done inputs are ignored in ISSUE.
- WAIT:
  - Only the selected unit's done is honoured; the non-selected unit's done is ignored.
  - On selected done: latch that unit's result → RESP.
  - Otherwise increment the counter. If the counter reaches TIMEOUT → RESP with result 32'h7FC00000 and err_o=1.
  - If done arrives in the same cycle the counter reaches TIMEOUT, done wins: normal result, no error.
- RESP (1 cycle):
  - copro_complete_o=1, copro_result_o driven.
  - op_count_o increments, wrapping from all-ones to 0.
  - Next state HOLD.
- HOLD (1 cycle):
  - copro_valid_i ignored, covering the CPU's release cycle.
  - Next state IDLE.
- copro_result_o keeps its value after RESP until the next RESP; consumers must qualify with copro_complete_o.
- Latency: valid sampled in IDLE at cycle 0, then ISSUE at cycle 1, then WAIT from cycle 2.
  - Unit done at cycle 1+L (L ≥ 1 cycles after start) gives complete at cycle 2+L. Minimum 3 cycles.
  - Illegal opcode: complete at cycle 1.
  - Timeout: complete at cycle 2+TIMEOUT.
- Back-to-back: the next request is accepted no earlier than 2 cycles after the complete pulse, i.e. in IDLE.
- Data path: no arithmetic in this block; results pass through unmodified.

Test Plan:
- Add: rst_i high 2 cycles, then opcode 00, op0=32'h3F800000 (1.0), op1=32'h40000000 (2.0); model adder done 2 cycles after start with 32'h40400000. Required: add_start_o one pulse with add_sub_o=0, complete at cycle 4 with result 32'h40400000, err_o=0, op_count_o=1, mul_start_o never high.
- Sub and mul in sequence: opcode 01 (5.0−3.0 → 32'h40000000), then opcode 10 (1.5×2.0 → 32'h40400000). Required: add_sub_o=1 on the first, mul_start_o on the second, second accepted only after HOLD, op_count_o=2. A spurious add_done_i during the mul WAIT is ignored.
- Illegal opcode 11: required complete 1 cycle after valid, result 32'h7FC00000, err_o=1, no start pulses. The next legal op clears err_o on accept.
- Timeout: TIMEOUT=8, multiplier never responds. Required: complete exactly 10 cycles after valid, result 32'h7FC00000, err_o=1. A late mul_done_i afterwards is ignored.
- Done/timeout tie: done asserted on the cycle the counter hits TIMEOUT. Required: unit result returned, err_o=0.
- Reset mid-WAIT, then op_count wrap: rst_i pulsed in WAIT gives busy_o=0 and all outputs 0 the next cycle; a subsequent adder done produces no complete. Then, with CNT_W=4, run 16 ops: op_count_o wraps 15 → 0.
